// File: rtl/framebuffer_port_arbiter.sv
// framebuffer_port_arbiter
// Shares the single-port framebuffer RAM between the display fetch path
// (reads, absolute priority) and the frame loader path (writes, parked in a
// holding buffer and retired in idle RAM cycles). A guard cycle after every
// read burst keeps the RAM output register stable for the fetch path.
//
// Build option: define FB_ARB_WRBUF2_EN to replace the 1-entry holding
// register with a 2-entry in-order FIFO.
module framebuffer_port_arbiter #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic                  wr_busy,
  output logic                  wr_starved,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  output logic                  ram_clk_en,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_GUARD = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  state_e                  state_q;
  state_e                  state_d;

  // Holding buffer view shared by both buffer variants
  logic                    buf_nonempty_s;
  logic [ADDR_WIDTH-1:0]   head_addr_s;
  logic [DATA_WIDTH-1:0]   head_data_s;
  logic                    busy_d;

  logic                    accept_s;
  logic                    retire_s;

  logic                    wr_ack_q;
  logic                    wr_busy_q;
  logic                    wr_starved_q;
  logic [7:0]              starve_q;
  logic [7:0]              starve_d;

  logic [ADDR_WIDTH-1:0]   ram_addr_q;
  logic [DATA_WIDTH-1:0]   ram_wdata_q;
  logic [ADDR_WIDTH-1:0]   ram_addr_s;
  logic [DATA_WIDTH-1:0]   ram_wdata_s;
  logic                    ram_we_s;
  logic                    ram_clk_en_s;

  // Read data passes straight through: the arbiter adds no read latency
  assign rd_data = ram_rdata;

  // Arbitration decision for this cycle; it is also the next registered state
  always_comb begin
    state_d = ST_IDLE;
    if (!reset) begin
      state_d = ST_IDLE;
    end else if (rd_req) begin
      state_d = ST_READ;
    end else if (state_q == ST_READ) begin
      state_d = ST_GUARD;
    end else if (buf_nonempty_s) begin
      state_d = ST_WRITE;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // State register
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign retire_s = (state_d == ST_WRITE);
  assign accept_s = reset & wr_req & ~wr_busy_q;

  // RAM port drive; idle and guard cycles hold the last address and data
  always_comb begin
    ram_addr_s   = ram_addr_q;
    ram_wdata_s  = ram_wdata_q;
    ram_we_s     = 1'b0;
    ram_clk_en_s = 1'b0;
    case (state_d)
      ST_READ: begin
        ram_addr_s   = rd_addr;
        ram_clk_en_s = 1'b1;
      end
      ST_WRITE: begin
        ram_addr_s   = head_addr_s;
        ram_wdata_s  = head_data_s;
        ram_we_s     = 1'b1;
        ram_clk_en_s = 1'b1;
      end
      default: begin
        ram_addr_s   = ram_addr_q;
        ram_wdata_s  = ram_wdata_q;
        ram_we_s     = 1'b0;
        ram_clk_en_s = 1'b0;
      end
    endcase
  end

  // Remember the last driven RAM address/data so idle cycles hold them
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      ram_addr_q  <= ram_addr_s;
      ram_wdata_q <= ram_wdata_s;
    end
  end

  assign ram_addr   = ram_addr_s;
  assign ram_wdata  = ram_wdata_s;
  assign ram_we     = ram_we_s;
  assign ram_clk_en = ram_clk_en_s;

`ifdef FB_ARB_WRBUF2_EN
  // Two-entry in-order FIFO: accept and retire may share an edge
  logic [ADDR_WIDTH-1:0] fifo_addr_q [2];
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic                  wptr_q;
  logic                  rptr_q;
  logic [1:0]            cnt_q;
  logic [1:0]            cnt_d;

  assign buf_nonempty_s = (cnt_q != 2'd0);
  assign head_addr_s    = fifo_addr_q[rptr_q];
  assign head_data_s    = fifo_data_q[rptr_q];
  assign busy_d         = (cnt_d == 2'd2);

  // Occupancy after this edge
  always_comb begin
    cnt_d = cnt_q;
    case ({accept_s, retire_s})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO storage and pointers
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      if (accept_s) begin
        fifo_addr_q[wptr_q] <= wr_addr;
        fifo_data_q[wptr_q] <= wr_data;
        wptr_q              <= ~wptr_q;
      end
      if (retire_s) begin
        rptr_q <= ~rptr_q;
      end
    end
  end
`else
  // Single holding register: stays busy through its retiring cycle
  logic                  hold_vld_q;
  logic                  hold_vld_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q;
  logic [DATA_WIDTH-1:0] hold_data_q;

  assign buf_nonempty_s = hold_vld_q;
  assign head_addr_s    = hold_addr_q;
  assign head_data_s    = hold_data_q;
  assign busy_d         = hold_vld_d;

  // Occupancy after this edge
  always_comb begin
    hold_vld_d = hold_vld_q;
    if (accept_s) begin
      hold_vld_d = 1'b1;
    end else if (retire_s) begin
      hold_vld_d = 1'b0;
    end else begin
      hold_vld_d = hold_vld_q;
    end
  end

  // Holding register storage
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      hold_vld_q  <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      if (accept_s) begin
        hold_addr_q <= wr_addr;
        hold_data_q <= wr_data;
      end
    end
  end
`endif

  // Saturating count of cycles a pending write has been held off
  always_comb begin
    starve_d = starve_q;
    if (!buf_nonempty_s || retire_s) begin
      starve_d = 8'd0;
    end else if (starve_q != 8'hFF) begin
      starve_d = starve_q + 8'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Loader handshake and status registers
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      wr_ack_q     <= 1'b0;
      wr_busy_q    <= 1'b0;
      wr_starved_q <= 1'b0;
      starve_q     <= 8'd0;
    end else begin
      wr_ack_q     <= accept_s;
      wr_busy_q    <= busy_d;
      starve_q     <= starve_d;
      wr_starved_q <= (int'(starve_d) >= STARVE_LIMIT);
    end
  end

  assign wr_ack     = wr_ack_q;
  assign wr_busy    = wr_busy_q;
  assign wr_starved = wr_starved_q;

endmodule

// File: tb/tb_framebuffer_port_arbiter.sv
// Directed bench for framebuffer_port_arbiter with a RAM model, a write
// scoreboard (expected RAM writes queued when the loader strobe is driven)
// and a shadow memory for read data. Build with FB_ARB_WRBUF2_EN to select
// the 2-entry buffer expectations.
module tb_framebuffer_port_arbiter;

`ifdef FB_ARB_WRBUF2_EN
  localparam bit BUF2 = 1'b1;
`else
  localparam bit BUF2 = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        reset;
  logic        rd_req;
  logic [10:0] rd_addr;
  logic [15:0] rd_data;
  logic        wr_req;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        wr_busy;
  logic        wr_starved;
  logic [10:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic        ram_clk_en;
  logic [15:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [26:0] wq [$];
  logic [15:0] ram_mem [0:2047];
  logic [15:0] sh_mem  [0:2047];
  logic        rd_pend = 1'b0;
  logic [15:0] rd_exp  = 16'd0;

  always #5 clk_in = ~clk_in;

  framebuffer_port_arbiter #(
    .ADDR_WIDTH  (11),
    .DATA_WIDTH  (16),
    .STARVE_LIMIT(4)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .wr_busy   (wr_busy),
    .wr_starved(wr_starved),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_clk_en(ram_clk_en),
    .ram_rdata (ram_rdata)
  );

  function automatic logic [15:0] pat(input logic [10:0] a);
    return {5'd0, a} ^ 16'hA5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single-port RAM model with clock enable and registered read data
  always @(posedge clk_in) begin
    if (ram_clk_en === 1'b1) begin
      if (ram_we === 1'b1) ram_mem[ram_addr] <= ram_wdata;
      else                 ram_rdata       <= ram_mem[ram_addr];
    end
  end

  // Scoreboard: retired writes in order, read data one cycle after the address
  always @(negedge clk_in) begin
    logic [26:0] e;
    if (reset !== 1'b1) begin
      rd_pend <= 1'b0;
    end else begin
      if (ram_we === 1'b1) begin
        chk("wr_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          chk("wr_addr", 32'(ram_addr), 32'(e[26:16]));
          chk("wr_data", 32'(ram_wdata), 32'(e[15:0]));
          sh_mem[e[26:16]] <= e[15:0];
        end
      end
      if (rd_pend) chk("rd_data", 32'(rd_data), 32'(rd_exp));
      rd_pend <= (rd_req === 1'b1);
      rd_exp  <= sh_mem[rd_addr];
    end
  end

  task automatic nxt();
    @(posedge clk_in);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_in);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && wq.size() != 0; i++) nxt();
    nxt();
    chk("drain", 32'(wq.size()), 32'd0);
  endtask

  task automatic push_wr();
    wq.push_back({wr_addr, wr_data});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram_mem[i] = pat(11'(i));
      sh_mem[i]  = pat(11'(i));
    end
    reset = 1'b0; rd_req = 1'b0; rd_addr = 11'd0;
    wr_req = 1'b0; wr_addr = 11'd0; wr_data = 16'd0;

    // Power-on reset state
    repeat (3) @(posedge clk_in);
    mid();
    chk("rst_ack",    32'(wr_ack),     32'd0);
    chk("rst_busy",   32'(wr_busy),    32'd0);
    chk("rst_starve", 32'(wr_starved), 32'd0);
    chk("rst_we",     32'(ram_we),     32'd0);
    chk("rst_cen",    32'(ram_clk_en), 32'd0);
    chk("rst_addr",   32'(ram_addr),   32'd0);
    chk("rst_wdata",  32'(ram_wdata),  32'd0);
    #2 reset = 1'b1;
    nxt();

    // Idle write, then a strobe during the retiring cycle
    wr_req = 1'b1; wr_addr = 11'h123; wr_data = 16'hF800; push_wr();
    mid(); chk("iw_busy0", 32'(wr_busy), 32'd0);
    nxt();
    wr_addr = 11'h124; wr_data = 16'h001F;
    if (BUF2) push_wr();
    mid();
    chk("iw_ack",   32'(wr_ack),    32'd1);
    chk("iw_busy",  32'(wr_busy),   32'(!BUF2));
    chk("iw_we",    32'(ram_we),    32'd1);
    chk("iw_addr",  32'(ram_addr),  32'h123);
    chk("iw_wdata", 32'(ram_wdata), 32'hF800);
    nxt();
    wr_req = 1'b0;
    mid();
    chk("nb_ack",  32'(wr_ack),  32'(BUF2));
    chk("nb_busy", 32'(wr_busy), 32'd0);
    chk("nb_we",   32'(ram_we),  32'(BUF2));
    nxt();
    mid();
    chk("idle_we",   32'(ram_we),     32'd0);
    chk("idle_cen",  32'(ram_clk_en), 32'd0);
    chk("idle_hold", 32'(ram_addr),   BUF2 ? 32'h124 : 32'h123);
    nxt();
    drain();

    // Read priority: 3 blocked read cycles, guard, then the write retires
    rd_req = 1'b1; rd_addr = 11'h7FF;
    wr_req = 1'b1; wr_addr = 11'h200; wr_data = 16'h07E0; push_wr();
    mid(); chk("rp_pre_addr", 32'(ram_addr), 32'h7FF);
    nxt();
    wr_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [10:0] a;
      a = (i == 1) ? 11'h440 : 11'h040;
      rd_addr = a;
      mid();
      chk("rp_we",     32'(ram_we),     32'd0);
      chk("rp_cen",    32'(ram_clk_en), 32'd1);
      chk("rp_addr",   32'(ram_addr),   32'(a));
      chk("rp_starve", 32'(wr_starved), 32'd0);
      nxt();
    end
    rd_req = 1'b0;
    mid();
    chk("rp_guard_we",  32'(ram_we),     32'd0);
    chk("rp_guard_cen", 32'(ram_clk_en), 32'd0);
    chk("rp_guard_stv", 32'(wr_starved), 32'd0);
    nxt();
    mid();
    chk("rp_wr_we",   32'(ram_we),     32'd1);
    chk("rp_wr_addr", 32'(ram_addr),   32'h200);
    chk("rp_wr_stv",  32'(wr_starved), 32'd1);
    nxt();
    mid();
    chk("rp_post_stv", 32'(wr_starved), 32'd0);
    chk("rp_post_we",  32'(ram_we),     32'd0);
    nxt();

    // Read/write race on the same address
    wr_req = 1'b1; wr_addr = 11'h300; wr_data = 16'hBEEF; push_wr();
    mid(); chk("rc_idle_we", 32'(ram_we), 32'd0);
    nxt();
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 11'h300;
    mid();
    chk("rc_we",   32'(ram_we),     32'd0);
    chk("rc_addr", 32'(ram_addr),   32'h300);
    chk("rc_cen",  32'(ram_clk_en), 32'd1);
    nxt();
    rd_req = 1'b0;
    mid();
    chk("rc_guard_cen", 32'(ram_clk_en), 32'd0);
    chk("rc_guard_we",  32'(ram_we),     32'd0);
    chk("rc_busy",      32'(wr_busy),    32'(!BUF2));
    nxt();
    mid();
    chk("rc_wr_we",    32'(ram_we),    32'd1);
    chk("rc_wr_wdata", 32'(ram_wdata), 32'hBEEF);
    nxt();
    rd_req = 1'b1; rd_addr = 11'h300;
    mid(); chk("rc_rd2_we", 32'(ram_we), 32'd0);
    nxt();
    rd_req = 1'b0;
    mid(); nxt();
    drain();

    // Starvation with a long read burst; a second strobe while held
    rd_req = 1'b1; rd_addr = 11'h010;
    wr_req = 1'b1; wr_addr = 11'h3C0; wr_data = 16'h1234; push_wr();
    mid(); nxt();
    for (int k = 1; k <= 8; k++) begin
      rd_addr = 11'h010 + 11'(k);
      wr_req  = (k == 2);
      if (k == 2) begin
        wr_addr = 11'h3C1; wr_data = 16'h5678;
        if (BUF2) push_wr();
      end
      mid();
      chk("sv_starve", 32'(wr_starved), 32'(k - 1 >= 4));
      if (k == 2) chk("sv_busy", 32'(wr_busy), 32'(!BUF2));
      if (k == 3) chk("sv_ack",  32'(wr_ack),  32'(BUF2));
      nxt();
    end
    rd_req = 1'b0; wr_req = 1'b0;
    mid(); chk("sv_guard_stv", 32'(wr_starved), 32'd1);
    nxt();
    mid();
    chk("sv_wr_we",   32'(ram_we),     32'd1);
    chk("sv_wr_addr", 32'(ram_addr),   32'h3C0);
    chk("sv_wr_stv",  32'(wr_starved), 32'd1);
    nxt();
    mid();
    chk("sv_post_stv", 32'(wr_starved), 32'd0);
    chk("sv_post_we",  32'(ram_we),     32'(BUF2));
    nxt();
    drain();

`ifdef FB_ARB_WRBUF2_EN
    // Backpressure: three strobes during a read burst, third refused
    for (int i = 0; i < 3; i++) begin
      rd_req = 1'b1; rd_addr = 11'h050 + 11'(i);
      wr_req = 1'b1; wr_addr = 11'h600 + 11'(i); wr_data = 16'hA000 + 16'(i);
      if (i < 2) push_wr();
      mid();
      chk("bp_busy", 32'(wr_busy), 32'(i == 2));
      if (i >= 1) chk("bp_ack", 32'(wr_ack), 32'd1);
      nxt();
    end
    rd_req = 1'b0; wr_req = 1'b0;
    mid();
    chk("bp_ack3", 32'(wr_ack),     32'd0);
    chk("bp_cen",  32'(ram_clk_en), 32'd0);
    nxt();
    mid(); chk("bp_w1", 32'(ram_addr), 32'h600); nxt();
    mid(); chk("bp_w2", 32'(ram_addr), 32'h601); nxt();
    mid();
    chk("bp_busy0", 32'(wr_busy), 32'd0);
    chk("bp_we0",   32'(ram_we),  32'd0);
    nxt();
`endif

    // Reset in the middle of a write with the buffer full
    rd_req = 1'b1; rd_addr = 11'h020;
    wr_req = 1'b1; wr_addr = 11'h5A0; wr_data = 16'h0F0F; push_wr();
    mid(); nxt();
    rd_addr = 11'h021; wr_addr = 11'h5A1; wr_data = 16'hF0F0;
    if (BUF2) push_wr();
    mid(); nxt();
    rd_req = 1'b0; wr_req = 1'b0;
    mid(); nxt();
    mid();
    chk("mr_we",   32'(ram_we),  32'd1);
    chk("mr_busy", 32'(wr_busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    wq.delete();
    chk("mr_ack",   32'(wr_ack),     32'd0);
    chk("mr_busy0", 32'(wr_busy),    32'd0);
    chk("mr_stv",   32'(wr_starved), 32'd0);
    chk("mr_we0",   32'(ram_we),     32'd0);
    chk("mr_cen",   32'(ram_clk_en), 32'd0);
    chk("mr_addr",  32'(ram_addr),   32'd0);
    chk("mr_wdata", 32'(ram_wdata),  32'd0);
    @(negedge clk_in);
    #2 reset = 1'b1;
    nxt();
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("ar_we",   32'(ram_we),  32'd0);
      chk("ar_ack",  32'(wr_ack),  32'd0);
      chk("ar_busy", 32'(wr_busy), 32'd0);
      nxt();
    end
    chk("ar_mem0", 32'(ram_mem[11'h5A0]), 32'(pat(11'h5A0)));
    chk("ar_mem1", 32'(ram_mem[11'h5A1]), 32'(pat(11'h5A1)));
    chk("final_q", 32'(wq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
